// File: rtl/sparc_exu_ecl_dcnt6_pkg.sv
// Shared definitions for the EXU ECL 6-bit iteration down-counter.
// Holds the FSM state encodings and the counter width constant.
package sparc_exu_ecl_dcnt6_pkg;

  localparam int unsigned Dcnt6Width = 6;

  // 2'b11 is deliberately unnamed; the FSM treats it as illegal and returns to idle.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } dcnt6_state_e;

endpackage

// File: rtl/sparc_exu_ecl_dcnt6_dp.sv
// Load/decrement/clear datapath for the iteration down-counter.
// Clear beats load beats decrement; decrement saturates at zero.
module sparc_exu_ecl_dcnt6_dp #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             se,
  input  logic             ld,
  input  logic             dec,
  input  logic             clr,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] q,
  output logic             zero
);

  logic [Width-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = din;
    end else if (dec && (q_q != '0)) begin
      q_d = q_q - Width'(1);
    end
  end

  // Scan enable freezes the functional update while the scan chain owns the flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (!se) begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);

endmodule

// File: rtl/sparc_exu_ecl_dcnt6_ctl.sv
// Loadable 6-bit iteration down-counter with start/done/ack handshake.
// Optional feature: define DCNT6_PAUSE_EN to add the pause input that holds RUN.
module sparc_exu_ecl_dcnt6_ctl
  import sparc_exu_ecl_dcnt6_pkg::*;
#(
  parameter int unsigned WIDTH = Dcnt6Width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             se,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             kill,
  input  logic             ack,
`ifdef DCNT6_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic             last,
  output logic             done
);

  dcnt6_state_e state_q, state_d;
  logic         ld, dec, clr, cnt_zero, run_hold;

`ifdef DCNT6_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  // Priority: kill > ack/start > count.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    if (kill) begin
      state_d = StIdle;
      clr     = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRun;
            ld      = 1'b1;
          end
        end
        StRun: begin
          if (!run_hold) begin
            if (cnt_zero) begin
              state_d = StDone;
            end else begin
              dec = 1'b1;
            end
          end
        end
        StDone: begin
          if (ack) begin
            if (start) begin
              state_d = StRun;
              ld      = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          clr     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else if (!se) begin
      state_q <= state_d;
    end
  end

  sparc_exu_ecl_dcnt6_dp #(
    .Width (WIDTH)
  ) u_dp (
    .clk   (clk),
    .reset (reset),
    .se    (se),
    .ld    (ld),
    .dec   (dec),
    .clr   (clr),
    .din   (load_val),
    .q     (cnt),
    .zero  (cnt_zero)
  );

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign last = busy & cnt_zero;

endmodule
